// File: rtl/npc_core_pkg.sv
// Shared types and constants for the multi-cycle NPC core sequencer.
// FSM states, IDU class codes, halt reasons and the default reset PC.
package npc_core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_REQ,
        ST_FETCH_WAIT,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WB,
        ST_HALT
    } state_e;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_JUMP   = 3'd1;
    localparam logic [2:0] CLS_BRANCH = 3'd2;
    localparam logic [2:0] CLS_LOAD   = 3'd3;
    localparam logic [2:0] CLS_STORE  = 3'd4;
    localparam logic [2:0] CLS_EBREAK = 3'd5;

    localparam logic [1:0] HC_EBREAK  = 2'd0;
    localparam logic [1:0] HC_ILLEGAL = 2'd1;
    localparam logic [1:0] HC_BUSERR  = 2'd2;
    localparam logic [1:0] HC_TIMEOUT = 2'd3;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

    function automatic logic cls_writes_rd(input logic [2:0] cls);
        return (cls == CLS_ALU) || (cls == CLS_JUMP) || (cls == CLS_LOAD);
    endfunction

endpackage

// File: rtl/npc_bus_watchdog.sv
// Cycle counter bounding how long the core may sit in a bus state.
// Counts while enabled, restarts on clear, flags expiry on the last allowed cycle.
module npc_bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt;

    assign w_cnt    = i_clr ? 16'd0 : r_cnt;
    assign o_expire = i_en && (w_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 16'd0;
        end else if (!i_en) begin
            r_cnt <= 16'd0;
        end else if (w_cnt != LIMIT) begin
            r_cnt <= w_cnt + 16'd1;
        end else begin
            r_cnt <= w_cnt;
        end
    end

endmodule

// File: rtl/npc_mc_core_ctrl.sv
// Multi-cycle sequencer: owns PC and RF write strobe, walks fetch and
// load/store through valid/ready handshakes, halts stickily on faults.
module npc_mc_core_ctrl
    import npc_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC,
    parameter int unsigned NR_REGS  = 32,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    input  logic        ifu_rsp_err,
    output logic [31:0] inst,
    input  logic [2:0]  dec_cls,
    input  logic [4:0]  dec_rd,
    input  logic [31:0] exu_result,
    input  logic        br_taken,
    output logic        lsu_req_valid,
    output logic        lsu_req_we,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    input  logic [31:0] lsu_rsp_data,
    input  logic        lsu_rsp_err,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_code,
    output logic        ebreak_pulse
);

    state_e      r_state;
    state_e      r_prev;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_ldata;
    logic [1:0]  r_code;
    logic        r_ebreak;
    logic        r_live;

    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_rd_bad;
    logic        w_wb_ok;
    logic        w_ifu_valid;
    logic        w_bus_st;
    logic        w_expire;

    // r_live keeps request valids low for the cycle following reset
    assign w_ifu_valid = r_live && (r_state == ST_FETCH_REQ);
    assign w_bus_st    = r_live && ((r_state == ST_FETCH_REQ)
                      || (r_state == ST_FETCH_WAIT)
                      || (r_state == ST_MEM_REQ)
                      || (r_state == ST_MEM_WAIT));

    assign w_pc4      = r_pc + 32'd4;
    assign w_misalign = |w_next_pc[1:0];
    assign w_rd_bad   = 32'(dec_rd) >= NR_REGS;
    assign w_wb_ok    = (r_state == ST_WB) && !w_misalign;

    always_comb begin
        w_next_pc = w_pc4;
        if (dec_cls == CLS_JUMP) begin
            w_next_pc = exu_result;
        end else if ((dec_cls == CLS_BRANCH) && br_taken) begin
            w_next_pc = exu_result;
        end
    end

    always_comb begin
        rf_wdata = exu_result;
        priority case (1'b1)
            (dec_cls == CLS_JUMP): rf_wdata = w_pc4;
            (dec_cls == CLS_LOAD): rf_wdata = r_ldata;
            default:               rf_wdata = exu_result;
        endcase
    end

    npc_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state != r_prev),
        .i_en     (w_bus_st),
        .o_expire (w_expire)
    );

    assign ifu_req_valid = w_ifu_valid;
    assign ifu_req_addr  = r_pc;
    assign inst          = r_inst;
    assign lsu_req_valid = (r_state == ST_MEM_REQ);
    assign lsu_req_we    = (r_state == ST_MEM_REQ) && (dec_cls == CLS_STORE);
    assign rf_wen        = w_wb_ok && cls_writes_rd(dec_cls) && (dec_rd != 5'd0);
    assign rf_waddr      = dec_rd;
    assign pc            = r_pc;
    assign retire        = w_wb_ok;
    assign halted        = (r_state == ST_HALT);
    assign halt_code     = r_code;
    assign ebreak_pulse  = r_ebreak;

    // Handshakes and responses are checked before expiry so they win a tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_FETCH_REQ;
            r_prev   <= ST_FETCH_REQ;
            r_pc     <= RESET_PC;
            r_inst   <= 32'd0;
            r_ldata  <= 32'd0;
            r_code   <= HC_EBREAK;
            r_ebreak <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            r_prev   <= r_state;
            r_ebreak <= 1'b0;
            unique case (r_state)
                ST_FETCH_REQ: begin
                    if (w_ifu_valid && ifu_req_ready) begin
                        r_state <= ST_FETCH_WAIT;
                    end else if (w_expire) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_TIMEOUT;
                    end
                end
                ST_FETCH_WAIT: begin
                    if (ifu_rsp_valid && ifu_rsp_err) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_BUSERR;
                    end else if (ifu_rsp_valid) begin
                        r_inst  <= ifu_rsp_data;
                        r_state <= ST_EXEC;
                    end else if (w_expire) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_TIMEOUT;
                    end
                end
                ST_EXEC: begin
                    priority case (1'b1)
                        (dec_cls == CLS_EBREAK): begin
                            r_state  <= ST_HALT;
                            r_code   <= HC_EBREAK;
                            r_ebreak <= 1'b1;
                        end
                        (dec_cls[2:1] == 2'b11),
                        (cls_writes_rd(dec_cls) && w_rd_bad): begin
                            r_state <= ST_HALT;
                            r_code  <= HC_ILLEGAL;
                        end
                        (dec_cls == CLS_LOAD),
                        (dec_cls == CLS_STORE): r_state <= ST_MEM_REQ;
                        default:                r_state <= ST_WB;
                    endcase
                end
                ST_MEM_REQ: begin
                    if (lsu_req_ready) begin
                        r_state <= ST_MEM_WAIT;
                    end else if (w_expire) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_TIMEOUT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (lsu_rsp_valid && lsu_rsp_err) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_BUSERR;
                    end else if (lsu_rsp_valid) begin
                        r_ldata <= lsu_rsp_data;
                        r_state <= ST_WB;
                    end else if (w_expire) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_TIMEOUT;
                    end
                end
                ST_WB: begin
                    if (w_misalign) begin
                        r_state <= ST_HALT;
                        r_code  <= HC_ILLEGAL;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= ST_FETCH_REQ;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_mc_core_ctrl.sv
// Scenario bench for npc_mc_core_ctrl: drives fetch/LSU buses and decode,
// scoreboards every retirement against a queue of expected RF writes.
module tb_npc_mc_core_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [2:0] C_ALU = 3'd0, C_JMP = 3'd1, C_BR = 3'd2;
    localparam logic [2:0] C_LD = 3'd3, C_ST = 3'd4, C_EBRK = 3'd5;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rsp_data;
    logic [31:0] inst;
    logic [2:0]  dec_cls;
    logic [4:0]  dec_rd;
    logic [31:0] exu_result;
    logic        br_taken;
    logic        lsu_req_valid, lsu_req_we, lsu_req_ready;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rsp_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        retire, halted, ebreak_pulse;
    logic [1:0]  halt_code;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    npc_mc_core_ctrl #(
        .RESET_PC (RST_PC),
        .NR_REGS  (16),
        .TIMEOUT  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .inst          (inst),
        .dec_cls       (dec_cls),
        .dec_rd        (dec_rd),
        .exu_result    (exu_result),
        .br_taken      (br_taken),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pc            (pc),
        .retire        (retire),
        .halted        (halted),
        .halt_code     (halt_code),
        .ebreak_pulse  (ebreak_pulse)
    );

    // Scoreboard: every retirement must match the oldest pending expectation
    always @(negedge clk) begin
        if (retire === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_retire: unexpected retire at pc=%h", pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rf_wen !== e.wen || pc !== e.pc ||
                    (e.wen && (rf_waddr !== e.waddr || rf_wdata !== e.wdata))) begin
                    fails++;
                    $display("FAIL sb_write: got wen=%b x%0d=%h pc=%h, want wen=%b x%0d=%h pc=%h",
                             rf_wen, rf_waddr, rf_wdata, pc, e.wen, e.waddr, e.wdata, e.pc);
                end
            end
        end else if (rf_wen === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL sb_wen: rf_wen=1 without retire, x%0d=%h", rf_waddr, rf_wdata);
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_dec(input logic [2:0] c, input logic [4:0] rd,
                           input logic [31:0] res, input logic tk);
        dec_cls    = c;
        dec_rd     = rd;
        exu_result = res;
        br_taken   = tk;
    endtask

    task automatic push(input logic wen, input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{wen, a, d, m_pc});
    endtask

    task automatic do_reset;
        rst = 1'b0;
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
        lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
        tick;
        tick;
        rst = 1'b1;
        exp_q.delete();
        m_pc = RST_PC;
        tick;
    endtask

    task automatic do_fetch(input logic [31:0] iw, input int dly, input logic err,
                            output logic ok, output logic [31:0] a);
        ok = 1'b1;
        a  = ifu_req_addr;
        for (int k = 0; k <= dly; k++) begin
            if (ifu_req_valid !== 1'b1 || ifu_req_addr !== a) ok = 1'b0;
            ifu_req_ready = (k == dly);
            tick;
        end
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data  = iw;
        ifu_rsp_err   = err;
        tick;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
    endtask

    task automatic do_mem(input int dly, input logic [31:0] d, input logic err,
                          output logic ok, output logic we);
        ok = 1'b1;
        we = lsu_req_we;
        for (int k = 0; k <= dly; k++) begin
            if (lsu_req_valid !== 1'b1 || lsu_req_we !== we) ok = 1'b0;
            lsu_req_ready = (k == dly);
            tick;
        end
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b1;
        lsu_rsp_data  = d;
        lsu_rsp_err   = err;
        tick;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_err   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_data = 0;
        lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0; lsu_rsp_data = 0;
        set_dec(C_ALU, 5'd0, 32'd0, 1'b0);
        tick;
        tick;
        tests++;
        if (pc !== RST_PC || inst !== 32'd0) begin
            fails++;
            $display("FAIL reset_regs: pc=%h inst=%h, want %h 0", pc, inst, RST_PC);
        end
        tests++;
        if ({ifu_req_valid, lsu_req_valid, rf_wen, retire, ebreak_pulse} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes: %b, want 00000",
                     {ifu_req_valid, lsu_req_valid, rf_wen, retire, ebreak_pulse});
        end
        tests++;
        if (halted !== 1'b0 || halt_code !== 2'd0) begin
            fails++;
            $display("FAIL reset_halt: halted=%b code=%0d, want 0 0", halted, halt_code);
        end
        rst = 1'b1;
        m_pc = RST_PC;
        tick;
        tests++;
        if (ifu_req_valid !== 1'b1 || ifu_req_addr !== RST_PC) begin
            fails++;
            $display("FAIL reset_fetch: valid=%b addr=%h, want 1 %h",
                     ifu_req_valid, ifu_req_addr, RST_PC);
        end
    endtask

    task automatic test_alu;
        logic ok; logic [31:0] a; int start;
        start = cyc;
        set_dec(C_ALU, 5'd1, 32'h0000_0005, 1'b0);
        push(1'b1, 5'd1, 32'h0000_0005);
        do_fetch(32'h0050_0093, 0, 1'b0, ok, a);
        tests++;
        if (!ok || a !== 32'h8000_0000) begin
            fails++;
            $display("FAIL alu_fetch: ok=%b addr=%h, want 1 80000000", ok, a);
        end
        tests++;
        if (inst !== 32'h0050_0093) begin
            fails++;
            $display("FAIL alu_inst: got %h, want 00500093", inst);
        end
        tick;
        tests++;
        if (retire !== 1'b1 || (cyc - start + 1) != 4) begin
            fails++;
            $display("FAIL alu_latency: retire=%b cycle=%0d, want 1 4", retire, cyc - start + 1);
        end
        tick;
        m_pc = m_pc + 32'd4;
        tests++;
        if (pc !== 32'h8000_0004 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0004) begin
            fails++;
            $display("FAIL alu_next: pc=%h valid=%b addr=%h, want 80000004 1 80000004",
                     pc, ifu_req_valid, ifu_req_addr);
        end
        set_dec(C_ALU, 5'd0, 32'h1234_5678, 1'b0);
        push(1'b0, 5'd0, 32'h0);
        do_fetch(32'h0000_0013, 0, 1'b0, ok, a);
        tick;
        tick;
        m_pc = m_pc + 32'd4;
        set_dec(C_ALU, 5'd15, 32'hCAFE_0001, 1'b0);
        push(1'b1, 5'd15, 32'hCAFE_0001);
        do_fetch(32'h0010_0793, 0, 1'b0, ok, a);
        tick;
        tick;
        m_pc = m_pc + 32'd4;
        tests++;
        if (pc !== 32'h8000_000C || halted !== 1'b0) begin
            fails++;
            $display("FAIL alu_b2b_pc: pc=%h halted=%b, want 8000000c 0", pc, halted);
        end
    endtask

    task automatic test_jump;
        logic ok; logic [31:0] a;
        do_reset;
        set_dec(C_JMP, 5'd1, 32'h8000_0010, 1'b0);
        push(1'b1, 5'd1, 32'h8000_0004);
        do_fetch(32'h0100_00EF, 0, 1'b0, ok, a);
        tick;
        tick;
        m_pc = 32'h8000_0010;
        tests++;
        if (pc !== 32'h8000_0010) begin
            fails++;
            $display("FAIL jal_pc: got %h, want 80000010", pc);
        end
        set_dec(C_JMP, 5'd1, 32'h8000_0012, 1'b0);
        do_fetch(32'h0120_00E7, 0, 1'b0, ok, a);
        tick;
        tests++;
        if (retire !== 1'b0 || rf_wen !== 1'b0) begin
            fails++;
            $display("FAIL jalr_wb: retire=%b wen=%b, want 0 0", retire, rf_wen);
        end
        tick;
        tests++;
        if (halted !== 1'b1 || halt_code !== 2'd1 || pc !== 32'h8000_0010) begin
            fails++;
            $display("FAIL jalr_halt: halted=%b code=%0d pc=%h, want 1 1 80000010",
                     halted, halt_code, pc);
        end
    endtask

    task automatic test_branch;
        logic ok; logic [31:0] a;
        do_reset;
        set_dec(C_BR, 5'd3, 32'h8000_0008, 1'b1);
        push(1'b0, 5'd0, 32'h0);
        do_fetch(32'h0020_8463, 0, 1'b0, ok, a);
        tick;
        tick;
        m_pc = 32'h8000_0008;
        tests++;
        if (pc !== 32'h8000_0008) begin
            fails++;
            $display("FAIL br_taken_pc: got %h, want 80000008", pc);
        end
        set_dec(C_BR, 5'd3, 32'h1234_5677, 1'b0);
        push(1'b0, 5'd0, 32'h0);
        do_fetch(32'h0020_8463, 0, 1'b0, ok, a);
        tick;
        tick;
        m_pc = m_pc + 32'd4;
        tests++;
        if (pc !== 32'h8000_000C || halted !== 1'b0) begin
            fails++;
            $display("FAIL br_not_taken: pc=%h halted=%b, want 8000000c 0", pc, halted);
        end
    endtask

    task automatic test_load_store;
        logic ok; logic we; logic [31:0] a; int start;
        do_reset;
        start = cyc;
        set_dec(C_LD, 5'd5, 32'h8000_1000, 1'b0);
        push(1'b1, 5'd5, 32'hDEAD_BEEF);
        do_fetch(32'h0000_2283, 0, 1'b0, ok, a);
        tick;
        do_mem(3, 32'hDEAD_BEEF, 1'b0, ok, we);
        tests++;
        if (!ok || we !== 1'b0) begin
            fails++;
            $display("FAIL load_req_hold: stable=%b we=%b, want 1 0", ok, we);
        end
        tests++;
        if (retire !== 1'b1 || (cyc - start + 1) != 9) begin
            fails++;
            $display("FAIL load_latency: retire=%b cycle=%0d, want 1 9", retire, cyc - start + 1);
        end
        tick;
        m_pc = m_pc + 32'd4;
        tests++;
        if (retire !== 1'b0 || pc !== 32'h8000_0004) begin
            fails++;
            $display("FAIL load_once: retire=%b pc=%h, want 0 80000004", retire, pc);
        end
        start = cyc;
        set_dec(C_ST, 5'd7, 32'h8000_1004, 1'b0);
        push(1'b0, 5'd0, 32'h0);
        do_fetch(32'h0050_2223, 0, 1'b0, ok, a);
        tick;
        do_mem(0, 32'h0, 1'b0, ok, we);
        tests++;
        if (we !== 1'b1 || retire !== 1'b1 || (cyc - start + 1) != 6) begin
            fails++;
            $display("FAIL store: we=%b retire=%b cycle=%0d, want 1 1 6",
                     we, retire, cyc - start + 1);
        end
        tick;
        m_pc = m_pc + 32'd4;
    endtask

    task automatic test_illegal;
        logic ok; logic [31:0] a;
        do_reset;
        set_dec(C_ALU, 5'd16, 32'h1, 1'b0);
        do_fetch(32'h0010_0813, 0, 1'b0, ok, a);
        tick;
        tests++;
        if (halted !== 1'b1 || halt_code !== 2'd1 || pc !== RST_PC) begin
            fails++;
            $display("FAIL illegal_rd: halted=%b code=%0d pc=%h, want 1 1 %h",
                     halted, halt_code, pc, RST_PC);
        end
    endtask

    task automatic test_ebreak;
        logic ok; logic [31:0] a; int bad;
        do_reset;
        set_dec(C_EBRK, 5'd0, 32'h0, 1'b0);
        do_fetch(32'h0010_0073, 0, 1'b0, ok, a);
        tick;
        tests++;
        if (ebreak_pulse !== 1'b1 || halted !== 1'b1 || halt_code !== 2'd0) begin
            fails++;
            $display("FAIL ebreak_entry: pulse=%b halted=%b code=%0d, want 1 1 0",
                     ebreak_pulse, halted, halt_code);
        end
        tick;
        tests++;
        if (ebreak_pulse !== 1'b0) begin
            fails++;
            $display("FAIL ebreak_pulse_len: got %b, want 0", ebreak_pulse);
        end
        bad = 0;
        ifu_req_ready = 1'b1;
        lsu_req_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (ifu_req_valid !== 1'b0 || lsu_req_valid !== 1'b0 || halted !== 1'b1) bad++;
            tick;
        end
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        tests++;
        if (bad != 0 || pc !== RST_PC) begin
            fails++;
            $display("FAIL ebreak_sticky: bad_cycles=%0d pc=%h, want 0 %h", bad, pc, RST_PC);
        end
    endtask

    task automatic test_timeout;
        logic ok; logic [31:0] a;
        do_reset;
        set_dec(C_ALU, 5'd2, 32'h0000_0077, 1'b0);
        push(1'b1, 5'd2, 32'h0000_0077);
        do_fetch(32'h0770_0113, 7, 1'b0, ok, a);
        tick;
        tests++;
        if (retire !== 1'b1 || !ok) begin
            fails++;
            $display("FAIL timeout_tie: retire=%b stable=%b, want 1 1", retire, ok);
        end
        tick;
        m_pc = m_pc + 32'd4;
        for (int k = 0; k < 7; k++) tick;
        tests++;
        if (halted !== 1'b0 || ifu_req_valid !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: halted=%b valid=%b, want 0 1", halted, ifu_req_valid);
        end
        tick;
        tests++;
        if (halted !== 1'b1 || halt_code !== 2'd3 || pc !== 32'h8000_0004) begin
            fails++;
            $display("FAIL timeout_halt: halted=%b code=%0d pc=%h, want 1 3 80000004",
                     halted, halt_code, pc);
        end
    endtask

    task automatic test_bus_err;
        logic ok; logic [31:0] a;
        do_reset;
        set_dec(C_ALU, 5'd1, 32'h5, 1'b0);
        do_fetch(32'h0050_0093, 0, 1'b1, ok, a);
        tests++;
        if (halted !== 1'b1 || halt_code !== 2'd2 || pc !== RST_PC || ebreak_pulse !== 1'b0) begin
            fails++;
            $display("FAIL fetch_err: halted=%b code=%0d pc=%h pulse=%b, want 1 2 %h 0",
                     halted, halt_code, pc, ebreak_pulse, RST_PC);
        end
    endtask

    task automatic test_reset_mid;
        logic ok; logic [31:0] a;
        do_reset;
        set_dec(C_LD, 5'd6, 32'h8000_2000, 1'b0);
        push(1'b1, 5'd6, 32'hBAD0_BAD0);
        do_fetch(32'h0000_2303, 0, 1'b0, ok, a);
        tick;
        lsu_req_ready = 1'b1;
        tick;
        lsu_req_ready = 1'b0;
        rst = 1'b0;
        tick;
        tests++;
        if (pc !== RST_PC || {ifu_req_valid, lsu_req_valid, rf_wen, retire, halted} !== 5'b0) begin
            fails++;
            $display("FAIL mid_reset: pc=%h strobes=%b, want %h 00000", pc,
                     {ifu_req_valid, lsu_req_valid, rf_wen, retire, halted}, RST_PC);
        end
        rst = 1'b1;
        exp_q.delete();
        m_pc = RST_PC;
        lsu_rsp_valid = 1'b1;
        lsu_rsp_data  = 32'hBAD0_BAD0;
        tick;
        tests++;
        if (ifu_req_valid !== 1'b1 || ifu_req_addr !== RST_PC || lsu_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_restart: ifu_valid=%b addr=%h lsu_valid=%b, want 1 %h 0",
                     ifu_req_valid, ifu_req_addr, lsu_req_valid, RST_PC);
        end
        set_dec(C_ALU, 5'd9, 32'h0000_0abc, 1'b0);
        push(1'b1, 5'd9, 32'h0000_0abc);
        do_fetch(32'h0ab0_0493, 0, 1'b0, ok, a);
        tick;
        tests++;
        if (retire !== 1'b1) begin
            fails++;
            $display("FAIL mid_stale: retire=%b, want 1", retire);
        end
        lsu_rsp_valid = 1'b0;
        tick;
        m_pc = m_pc + 32'd4;
        tests++;
        if (pc !== 32'h8000_0004) begin
            fails++;
            $display("FAIL mid_pc: got %h, want 80000004", pc);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_jump;
        test_branch;
        test_load_store;
        test_illegal;
        test_ebreak;
        test_timeout;
        test_bus_err;
        test_reset_mid;
        tick;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d expected retirements never seen, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/npc_mc_core_ctrl.md
Name: npc_mc_core_ctrl

Overview:
- Multi-cycle sequencer for the next-generation NPC core. Replaces the single-cycle "PC updates every clock" scheme.
- Owns the PC and register-file write strobe. Sequences instruction fetch and load/store through valid/ready handshakes.
- Halts on ebreak, illegal instruction, bus error or bus timeout.
- Sits between IDU/EXU (combinational) and the instruction/data bus adapters.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset.
- NR_REGS, 32, architectural register count (16 = RV32E); rd >= NR_REGS is illegal.
- TIMEOUT, 255, max cycles spent in any bus request/wait state before a timeout halt (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (rst=0 resets on posedge clk)
- ifu_req_valid  out  1  fetch request
- ifu_req_addr  out  32  fetch address (= pc)
- ifu_req_ready  in  1  fetch request accepted
- ifu_rsp_valid  in  1  fetch response
- ifu_rsp_data  in  32  instruction word
- ifu_rsp_err  in  1  fetch bus error (qualified by ifu_rsp_valid)
- inst  out  32  latched instruction to IDU
- dec_cls  in  3  IDU class: 0 ALU, 1 JUMP, 2 BRANCH, 3 LOAD, 4 STORE, 5 EBREAK, 6/7 ILLEGAL
- dec_rd  in  5  destination register
- exu_result  in  32  ALU result / jump-branch target
- br_taken  in  1  branch condition
- lsu_req_valid  out  1  data request (address/wdata driven by EXU)
- lsu_req_we  out  1  1 = store
- lsu_req_ready  in  1  data request accepted
- lsu_rsp_valid  in  1  data response
- lsu_rsp_data  in  32  load data
- lsu_rsp_err  in  1  data bus error
- rf_wen  out  1  register write enable
- rf_waddr  out  5  write index
- rf_wdata  out  32  write data
- pc  out  32  current PC
- retire  out  1  one-cycle pulse per retired instruction
- halted  out  1  sticky halt
- halt_code  out  2  0 ebreak, 1 illegal, 2 bus error, 3 timeout
- ebreak_pulse  out  1  one cycle on entry to HALT with code 0 (drives DPI notify)

Behaviour:
- Reset values:
  - state FETCH_REQ, pc=RESET_PC, inst=0.
  - All valid/wen/pulse outputs 0; halted=0, halt_code=0; watchdog=0.
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- FETCH_REQ:
  - ifu_req_valid=1, addr=pc held stable until ifu_req_ready.
  - Handshake cycle -> FETCH_WAIT.
- FETCH_WAIT:
  - On ifu_rsp_valid: if err -> HALT(2); else latch inst -> EXEC.
  - A response is legal no earlier than one cycle after the handshake.
- EXEC (decode valid on the latched inst):
  - EBREAK -> HALT(0).
  - ILLEGAL, or rd >= NR_REGS for ALU/JUMP/LOAD -> HALT(1).
  - LOAD/STORE -> MEM_REQ.
  - Otherwise -> WB.
- MEM_REQ:
  - lsu_req_valid=1, we=(cls==STORE); hold until ready -> MEM_WAIT.
- MEM_WAIT:
  - On lsu_rsp_valid: err -> HALT(2); else latch load data -> WB.
  - Store completion also needs lsu_rsp_valid.
- WB (one cycle):
  - next_pc: JUMP -> exu_result; BRANCH -> br_taken ? exu_result : pc+4; else pc+4.
  - If next_pc[1:0]!=0 -> HALT(1): no write, no retire, pc unchanged.
  - Otherwise:
    - rf_wen = (cls in ALU/JUMP/LOAD) && dec_rd!=0.
    - rf_wdata: JUMP -> pc+4; LOAD -> latched data; else exu_result.
    - pc <= next_pc, retire=1 -> FETCH_REQ.
- Latency: zero-wait bus (ready same cycle, rsp next cycle).
  - ALU/JUMP/BRANCH = 4 cycles/instr.
  - LOAD/STORE = 6 cycles/instr.
- Watchdog:
  - Clears on each state change.
  - Increments each cycle spent in FETCH_REQ/FETCH_WAIT/MEM_REQ/MEM_WAIT.
  - Reaching TIMEOUT -> HALT(3).
  - A timeout coincident with a response: the response wins.
- HALT:
  - Sticky until reset; pc frozen at the offending instruction.
  - No bus requests.
  - halt_code is written once, on entry.
- Spurious rsp_valid outside the matching wait state is ignored.
- Reset mid-transaction: the FSM returns to FETCH_REQ next edge; in-flight responses arriving later are ignored until FETCH_WAIT is re-entered.
- Arithmetic: pc+4 wraps modulo 2^32.

Decomposition:
- Package npc_core_pkg:
  - state enum
  - dec_cls codes
  - halt_code values
  - RESET_PC default
- Sub-module npc_bus_watchdog: parametrised counter with clear/enable/expire.

Test Plan:
1. ALU addi x1 at 0x8000_0000, zero-wait bus -> rf_wen with waddr=1 in cycle 4, retire pulse, pc=0x8000_0004; next fetch addr 0x8000_0004.
2. JAL target 0x8000_0010, rd=1 -> rf_wdata=0x8000_0004, pc=0x8000_0010; JALR target 0x8000_0012 -> halt_code=1, pc unchanged, no write.
3. LOAD with lsu_req_ready delayed 3 cycles, rsp data 0xDEADBEEF -> request held stable, rf_wdata=0xDEADBEEF, retire exactly once.
4. EBREAK -> ebreak_pulse for 1 cycle, halted=1, code 0; later ifu_req_valid stays 0 for 100 cycles.
5. TIMEOUT=8, ifu_req_ready never asserted -> HALT code 3 after 8 cycles; ifu_rsp_err=1 on another fetch -> code 2.
6. rst=0 asserted in MEM_WAIT, stale lsu_rsp_valid arriving afterwards -> pc=RESET_PC, outputs cleared, stale response ignored, fetch restarts.
